// File: rtl/dds_key_ctrl.sv
// -----------------------------------------------------------------------------
// dds_key_ctrl
// Upstream control stage for the dual-channel DDS / AD9767 generator.
// Four active-low push keys are synchronized, debounced and turned into
// single-cycle press events. Each event steps the frequency or phase word of
// DDS channel A or B. All outputs are registered and drive the DDS
// accumulators directly.
//
// Ports:
//   Clk       - system clock
//   Reset_n   - asynchronous active-low reset
//   Key[3:0]  - raw keys, active-low, asynchronous to Clk
//   FwordA/B  - channel A/B frequency word = FBASE * (index + 1), index 0..7
//   PwordA/B  - channel A/B phase offset, stepped by PSTEP, wraps mod 2^PW
//   Key_Flag  - 1-cycle pulse per accepted press (bit per key)
//   Upd       - 1-cycle strobe in the cycle any word changes
//
// Key mapping: Key[0] -> FwordA, Key[1] -> FwordB,
//              Key[2] -> PwordA, Key[3] -> PwordB.
//
// Optional build macro DDS_KEY_AUTOREPEAT_EN: while a key stays pressed, an
// extra press event is issued every REPEAT_CYCLES cycles. Without the macro
// each press yields exactly one event and REPEAT_CYCLES only gets a sanity
// check.
// -----------------------------------------------------------------------------
module dds_key_ctrl #(
  parameter int FW              = 32,
  parameter int PW              = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FBASE           = 85899,
  parameter int PSTEP           = 1024,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [3:0]    Key,
  output logic [FW-1:0] FwordA,
  output logic [FW-1:0] FwordB,
  output logic [PW-1:0] PwordA,
  output logic [PW-1:0] PwordB,
  output logic [3:0]    Key_Flag,
  output logic          Upd
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity: the top frequency word FBASE*8 must be
  // representable, and the repeat period must be a positive cycle count.
  if (longint'(FBASE) * 64'sd8 >= (64'sd1 <<< FW)) begin : gBadFbase
    $error("dds_key_ctrl: FBASE*8 does not fit in FW bits");
  end
  if (REPEAT_CYCLES < 1) begin : gBadRepeat
    $error("dds_key_ctrl: REPEAT_CYCLES must be at least 1");
  end

  logic [3:0]    keySync1_r;
  logic [3:0]    keySync2_r;
  logic [3:0]    keyLevel_r;      // debounced level, 1 = released
  logic [3:0]    keyLevelDly_r;   // debounced level one cycle earlier
  logic [CW-1:0] debCnt_r [4];
  logic [3:0]    pressEvt_s;
  logic [2:0]    idxA_r;
  logic [2:0]    idxB_r;
  logic [2:0]    idxANext_s;
  logic [2:0]    idxBNext_s;

  // Frequency word for a given index, computed at FW width.
  function automatic logic [FW-1:0] freqWord(input logic [2:0] idx);
    freqWord = FW'(FBASE) * (FW'(idx) + FW'(1));
  endfunction

  // Two-flop synchronizer for the asynchronous key pins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keySync1_r <= 4'b1111;
      keySync2_r <= 4'b1111;
    end else begin
      keySync1_r <= Key;
      keySync2_r <= keySync1_r;
    end
  end

  // Per-key debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples differ from the current debounced level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keyLevel_r <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        debCnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (keySync2_r[i] == keyLevel_r[i]) begin
          debCnt_r[i] <= '0;
        end else if (debCnt_r[i] == DEB_LAST) begin
          keyLevel_r[i] <= keySync2_r[i];
          debCnt_r[i]   <= '0;
        end else begin
          debCnt_r[i] <= debCnt_r[i] + CW'(1);
        end
      end
    end
  end

`ifdef DDS_KEY_AUTOREPEAT_EN
  localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] holdCnt_r [4];
  logic [3:0]    repeatHit_s;

  // A held key fires a repeat event each time its hold counter wraps.
  always_comb begin
    repeatHit_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      repeatHit_s[i] = ~keyLevel_r[i] && (holdCnt_r[i] == REP_LAST);
    end
  end

  // Hold counters run while the debounced level is low, clear on release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        holdCnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (keyLevel_r[i] || repeatHit_s[i]) begin
          holdCnt_r[i] <= '0;
        end else begin
          holdCnt_r[i] <= holdCnt_r[i] + RW'(1);
        end
      end
    end
  end
`else
  logic [3:0] repeatHit_s;

  // No auto-repeat: only the 1->0 edge of the debounced level is an event.
  always_comb begin
    repeatHit_s = 4'b0000;
  end
`endif

  // Press events: falling edge of the debounced level, plus repeats.
  always_comb begin
    pressEvt_s = (keyLevelDly_r & ~keyLevel_r) | repeatHit_s;
  end

  // Next frequency index; 3-bit arithmetic gives the 7 -> 0 wrap.
  always_comb begin
    idxANext_s = idxA_r + 3'd1;
    idxBNext_s = idxB_r + 3'd1;
  end

  // Registered press flags, one cycle after the debounced edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keyLevelDly_r <= 4'b1111;
      Key_Flag      <= 4'b0000;
    end else begin
      keyLevelDly_r <= keyLevel_r;
      Key_Flag      <= pressEvt_s;
    end
  end

  // Word updates, one cycle after the flag, with a shared update strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idxA_r <= 3'd0;
      idxB_r <= 3'd0;
      FwordA <= FW'(FBASE);
      FwordB <= FW'(FBASE);
      PwordA <= '0;
      PwordB <= '0;
      Upd    <= 1'b0;
    end else begin
      Upd <= |Key_Flag;
      if (Key_Flag[0]) begin
        idxA_r <= idxANext_s;
        FwordA <= freqWord(idxANext_s);
      end
      if (Key_Flag[1]) begin
        idxB_r <= idxBNext_s;
        FwordB <= freqWord(idxBNext_s);
      end
      if (Key_Flag[2]) begin
        PwordA <= PwordA + PW'(PSTEP);
      end
      if (Key_Flag[3]) begin
        PwordB <= PwordB + PW'(PSTEP);
      end
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_key_ctrl
// Scoreboard bench for dds_key_ctrl with DEBOUNCE_CYCLES = 200. The stimulus
// side drives keys and pushes the expected word set of every accepted press
// into a queue; the monitor pops one entry per Upd strobe and compares.
// -----------------------------------------------------------------------------
module tb_dds_key_ctrl;

  localparam int D  = 200;
  localparam int FB = 85899;
  localparam int PS = 1024;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  Key = 4'b1111;
  logic [31:0] FwordA, FwordB;
  logic [11:0] PwordA, PwordB;
  logic [3:0]  Key_Flag;
  logic        Upd;

  always #5 Clk = ~Clk;

  dds_key_ctrl #(
    .FW(32), .PW(12), .DEBOUNCE_CYCLES(D), .FBASE(FB), .PSTEP(PS), .REPEAT_CYCLES(1000)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Key(Key),
    .FwordA(FwordA), .FwordB(FwordB), .PwordA(PwordA), .PwordB(PwordB),
    .Key_Flag(Key_Flag), .Upd(Upd)
  );

  typedef struct {
    logic [3:0]  flag;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [11:0] pa;
    logic [11:0] pb;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: frequency indices and phase offsets.
  int mIdxA, mIdxB, mPa, mPb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void modelReset();
    mIdxA = 0; mIdxB = 0; mPa = 0; mPb = 0;
  endfunction

  function automatic logic [31:0] freqOf(input int idx);
    return 32'(FB * (idx + 1));
  endfunction

  // Apply one press event (possibly several keys at once) to the model.
  function automatic void modelPress(input logic [3:0] mask);
    exp_t e;
    if (mask[0]) mIdxA = (mIdxA + 1) % 8;
    if (mask[1]) mIdxB = (mIdxB + 1) % 8;
    if (mask[2]) mPa = (mPa + PS) % 4096;
    if (mask[3]) mPb = (mPb + PS) % 4096;
    e.flag = mask;
    e.fa = freqOf(mIdxA);
    e.fb = freqOf(mIdxB);
    e.pa = 12'(mPa);
    e.pb = 12'(mPb);
    expQ.push_back(e);
  endfunction

  // Monitor: checks flag pulse width and every Upd strobe against the queue.
  logic [3:0] prevFlag = 4'b0000;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prevFlag <= 4'b0000;
    end else begin
      if (Key_Flag != 4'b0000) check("flag_pulse_width", prevFlag, 4'b0000);
      if (Upd) begin
        if (expQ.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("flag_before_upd", prevFlag, e.flag);
          check("FwordA", FwordA, e.fa);
          check("FwordB", FwordB, e.fb);
          check("PwordA", PwordA, e.pa);
          check("PwordB", PwordB, e.pb);
        end
      end
      prevFlag <= Key_Flag;
    end
  end

  // Count posedges until Key_Flag goes nonzero, bounded.
  task automatic measureFlag(input string name, input int req);
    int n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (Key_Flag == 4'b0000 && n < 1000);
    check(name, n, req);
  endtask

  // Press the keys in mask for hold cycles, then release for rel cycles.
  task automatic pressRel(input logic [3:0] mask, input int hold, input int rel);
    @(negedge Clk);
    Key = ~mask;
    if (mask != 4'b0000) modelPress(mask);
    repeat (hold) @(negedge Clk);
    Key = 4'b1111;
    repeat (rel) @(negedge Clk);
  endtask

  initial begin
    // Reset values while reset is held.
    Reset_n = 1'b0;
    Key = 4'b1111;
    modelReset();
    repeat (10) @(negedge Clk);
    check("rst_FwordA", FwordA, 32'd85899);
    check("rst_FwordB", FwordB, 32'd85899);
    check("rst_PwordA", PwordA, 12'd0);
    check("rst_PwordB", PwordB, 12'd0);
    check("rst_Key_Flag", Key_Flag, 4'b0000);
    check("rst_Upd", Upd, 1'b0);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Clean press on Key[0] with latency check.
    @(negedge Clk);
    Key = 4'b1110;
    modelPress(4'b0001);
    measureFlag("press_flag_latency", D + 3);
    check("press_flag_value", Key_Flag, 4'b0001);
    @(posedge Clk); #1;
    check("press_FwordA", FwordA, 32'd171798);
    check("press_Upd", Upd, 1'b1);
    repeat (300) @(negedge Clk);
    Key = 4'b1111;
    repeat (300) @(negedge Clk);

    // Seven more Key[0] presses: index wraps back to 0.
    for (int i = 0; i < 7; i++) pressRel(4'b0001, 250, 250);
    check("wrap_FwordA", FwordA, 32'd85899);

    // Four Key[3] presses: phase wraps to 0.
    for (int i = 0; i < 4; i++) pressRel(4'b1000, 250, 250);
    check("wrap_PwordB", PwordB, 12'd0);

    // Independent and simultaneous presses.
    pressRel(4'b1000, 500, 300);
    pressRel(4'b0010, 500, 300);
    pressRel(4'b1010, 500, 300);

    // Bounce on Key[1]: 50-cycle toggles never qualify.
    @(negedge Clk);
    for (int t = 0; t < 20; t++) begin
      Key[1] = ~Key[1];
      repeat (50) @(negedge Clk);
    end
    Key = 4'b1111;
    repeat (400) @(negedge Clk);
    check("bounce_FwordB", FwordB, freqOf(mIdxB));

    // Randomized presses of random key subsets.
    for (int r = 0; r < 20; r++) begin
      pressRel(4'($urandom_range(1, 15)), $urandom_range(210, 500), $urandom_range(210, 400));
    end

    // Randomized bounce bursts: every run shorter than the debounce window.
    for (int r = 0; r < 8; r++) begin
      int k;
      int nt;
      k  = $urandom_range(0, 3);
      nt = $urandom_range(2, 12);
      @(negedge Clk);
      for (int t = 0; t < nt; t++) begin
        Key[k] = ~Key[k];
        repeat ($urandom_range(5, 150)) @(negedge Clk);
      end
      Key = 4'b1111;
      repeat (300) @(negedge Clk);
    end

    // Reset in the middle of a Key[2] hold, key still held afterwards.
    check("queue_before_reset", expQ.size(), 0);
    @(negedge Clk);
    Key = 4'b1011;
    repeat (100) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_PwordA", PwordA, 12'd0);
    check("midrst_FwordA", FwordA, 32'd85899);
    check("midrst_Key_Flag", Key_Flag, 4'b0000);
    check("midrst_Upd", Upd, 1'b0);
    modelReset();
    expQ.delete();
    repeat (10) @(negedge Clk);
    Reset_n = 1'b1;
    modelPress(4'b0100);
    measureFlag("post_reset_flag_latency", D + 3);
    check("post_reset_flag_value", Key_Flag, 4'b0100);
    repeat (300) @(negedge Clk);
    Key = 4'b1111;
    repeat (300) @(negedge Clk);

    // Drain the scoreboard with a bounded wait.
    begin
      int n = 0;
      while (expQ.size() != 0 && n < 2000) begin
        @(negedge Clk);
        n++;
      end
    end
    check("scoreboard_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
